// File: rtl/display_layer_pkg.sv
// Shared types for the display layer sequencer: state encoding, layer bit positions
// and the per-state layer masks.
package display_layer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    HIT   = 3'd2,
    CLEAR = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int LAYER_W          = 9;
  localparam int LAYER_GAME_OVER  = 0;
  localparam int LAYER_COLUMNS    = 1;
  localparam int LAYER_METADATA   = 2;
  localparam int LAYER_BORDERS    = 3;
  localparam int LAYER_BLAST      = 4;
  localparam int LAYER_PLAYER     = 5;
  localparam int LAYER_ENEMY      = 6;
  localparam int LAYER_BOMB       = 7;
  localparam int LAYER_DOOR_IDOL  = 8;

  localparam logic [LAYER_W-1:0] MASK_IDLE       = 9'h008;
  localparam logic [LAYER_W-1:0] MASK_PLAY       = 9'h1FE;
  localparam logic [LAYER_W-1:0] MASK_CLEAR      = 9'h10E;
  localparam logic [LAYER_W-1:0] MASK_OVER       = 9'h001;
  localparam logic [LAYER_W-1:0] MASK_OVER_BLINK = 9'h00E;

  // Layer enables for a state, given the player flash bit and the blink flag.
  function automatic logic [LAYER_W-1:0] layer_mask(state_t s, logic flash, logic blink);
    logic [LAYER_W-1:0] m;
    m = MASK_IDLE;
    case (s)
      IDLE:    m[LAYER_GAME_OVER] = blink;
      PLAY:    m = MASK_PLAY;
      HIT: begin
        m = MASK_PLAY;
        m[LAYER_PLAYER] = flash;
      end
      CLEAR:   m = MASK_CLEAR;
      OVER:    m = MASK_OVER | (blink ? MASK_OVER_BLINK : '0);
      default: m = MASK_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame counter (saturating) and blink flag generator; both restart on clear.
module frame_timer #(
  parameter int CNT_W        = 8,
  parameter int BLINK_FRAMES = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             startOfFrame,
  output logic [CNT_W-1:0] count,
  output logic             blink
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      count     <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (startOfFrame) begin
      if (count != '1) count <= count + CNT_W'(1);
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/display_layer_sequencer.sv
// Game-phase FSM driving the per-layer draw enables.
// Optional macro HIT_FLASH_EN: enables the HIT state (player flash after a collision).
module display_layer_sequencer
  import display_layer_pkg::*;
#(
  parameter int BLINK_FRAMES = 16,
  parameter int HIT_FRAMES   = 64,
  parameter int CLEAR_FRAMES = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               start_game,
  input  logic               player_hit,
  input  logic               level_done,
  input  logic               lives_zero,
  output logic [LAYER_W-1:0] layer_en,
  output logic               game_active,
  output logic [2:0]         state_out
);

  localparam int MAX_A      = (BLINK_FRAMES > HIT_FRAMES) ? BLINK_FRAMES : HIT_FRAMES;
  localparam int MAX_FRAMES = (MAX_A > CLEAR_FRAMES) ? MAX_A : CLEAR_FRAMES;
  localparam int CNT_RAW    = $clog2(MAX_FRAMES) + 1;
  // At least 3 bits so the HIT flash can always use counter bit 2.
  localparam int CNT_W      = (CNT_RAW < 3) ? 3 : CNT_RAW;

  state_t           state, state_next;
  logic             state_change;
  logic [CNT_W-1:0] count;
  logic             blink;
  logic             flash_eff, blink_eff;

`ifndef HIT_FLASH_EN
  logic unused_player_hit;
  assign unused_player_hit = player_hit;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_game) state_next = PLAY;
      PLAY: begin
        if (lives_zero)      state_next = OVER;
        else if (level_done) state_next = CLEAR;
`ifdef HIT_FLASH_EN
        else if (player_hit) state_next = HIT;
`endif
      end
`ifdef HIT_FLASH_EN
      HIT: begin
        if (lives_zero)                       state_next = OVER;
        else if (count >= CNT_W'(HIT_FRAMES)) state_next = PLAY;
      end
`endif
      CLEAR: if (count >= CNT_W'(CLEAR_FRAMES)) state_next = PLAY;
      OVER:  if (start_game) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign state_change = (state_next != state);

  frame_timer #(
    .CNT_W        (CNT_W),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_frame_timer (
    .clk          (clk),
    .clear        (reset | state_change),
    .startOfFrame (startOfFrame),
    .count        (count),
    .blink        (blink)
  );

  // Entering a state restarts the timer, so the new mask must see fresh values.
  assign flash_eff = state_change ? 1'b0 : count[2];
  assign blink_eff = state_change ? 1'b0 : blink;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      layer_en    <= MASK_IDLE;
      game_active <= 1'b0;
    end else begin
      state       <= state_next;
      layer_en    <= layer_mask(state_next, flash_eff, blink_eff);
      game_active <= (state_next == PLAY) || (state_next == HIT);
    end
  end

  assign state_out = state;

endmodule

// File: doc/display_layer_sequencer.md
DISPLAY_LAYER_SEQUENCER -- requirements
Module: display_layer_sequencer

Interface
REQ-001 SHALL have parameter BLINK_FRAMES, default 16: frames per half-period of the title/game-over blink.
REQ-002 SHALL have parameter HIT_FRAMES, default 64: frames the player layer flashes after a hit.
REQ-003 SHALL have parameter CLEAR_FRAMES, default 120: frames the level-clear hold lasts before play resumes.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port startOfFrame, input, 1: one-clk pulse per VGA frame.
REQ-007 SHALL have port start_game, input, 1: one-clk pulse from the key decoder.
REQ-008 SHALL have port player_hit, input, 1: one-clk pulse on a player/blast or player/enemy collision.
REQ-009 SHALL have port level_done, input, 1: one-clk pulse when the door is reached.
REQ-010 SHALL have port lives_zero, input, 1: level signal, high when no lives remain.
REQ-011 SHALL have port layer_en, output, 9: per-layer draw enable, ANDed with each DR before the objects mux; bit0 game_over, 1 columns, 2 metadata, 3 borders, 4 blast, 5 player, 6 enemy, 7 bomb, 8 door_idol.
REQ-012 SHALL have port game_active, output, 1: high in PLAY and HIT; gates movement and timers elsewhere.
REQ-013 SHALL have port state_out, output, 3: current state encoding, for debug and metadata.

Function
REQ-014 SHALL implement FSM states IDLE, PLAY, HIT, CLEAR, OVER.
REQ-015 SHALL move IDLE->PLAY on start_game.
REQ-016 SHALL move PLAY->HIT on player_hit.
REQ-017 SHALL move PLAY->CLEAR on level_done.
REQ-018 SHALL move PLAY or HIT->OVER on lives_zero.
REQ-019 SHALL move HIT->PLAY when HIT_FRAMES frames have elapsed.
REQ-020 SHALL move CLEAR->PLAY when CLEAR_FRAMES frames have elapsed.
REQ-021 SHALL move OVER->IDLE on start_game.
REQ-022 SHALL resolve simultaneous events with priority lives_zero > level_done > player_hit > start_game; lower-priority pulses in that cycle are dropped.
REQ-023 SHALL ignore player_hit while already in HIT; the frame counter is not restarted.
REQ-024 SHALL use a frame counter that clears on every state change and increments on startOfFrame only, saturating at its maximum.
REQ-025 SHALL toggle a blink flag every BLINK_FRAMES frames in IDLE and OVER, and clear it on entry to those states.
REQ-026 SHALL drive layer_en in IDLE as bit0=blink, bit3=1, all other bits 0.
REQ-027 SHALL drive layer_en in PLAY as bits1-8=1, bit0=0.
REQ-028 SHALL drive layer_en in HIT as in PLAY, with bit5 = frame counter bit2 so the player flashes every 4 frames.
REQ-029 SHALL drive layer_en in CLEAR as bits1,2,3,8=1, all other bits 0.
REQ-030 SHALL drive layer_en in OVER as bit0=1, bits1,2,3=blink, all other bits 0.
REQ-031 SHALL register all outputs, giving 1-clk latency from the input pulse to the new layer_en.
REQ-032 SHALL size the counter width with $clog2 of the largest frame parameter plus 1.

Reset
REQ-033 SHALL on reset clear the state to IDLE, the counter to 0, blink to 0, layer_en to 9'h008, game_active to 0, and state_out to IDLE; reset overrides all inputs in the same cycle, including mid-HIT or mid-CLEAR.

Configuration
REQ-034 SHALL with HIT_FLASH_EN defined implement the HIT state as specified above.
REQ-035 SHALL with HIT_FLASH_EN undefined ignore player_hit, never enter HIT, and omit the HIT logic from synthesis.

Structure
REQ-036 SHALL put the state enum, the layer bit-index localparams and the default layer masks in package display_layer_pkg.
REQ-037 SHALL place the frame counter and blink generator in sub-module frame_timer, with inputs clear and startOfFrame and outputs count and blink.

Verification
REQ-038 SHALL cover: reset, then start_game -> 1 clk later layer_en=9'h1FE and game_active=1.
REQ-039 SHALL cover: player_hit in PLAY, 64 frames -> bit5 toggles every 4 frames, then return to PLAY with layer_en=9'h1FE.
REQ-040 SHALL cover: level_done and player_hit in the same clk -> CLEAR with layer_en=9'h10E, and PLAY after 120 frames.
REQ-041 SHALL cover: lives_zero during HIT -> OVER, bit0=1, bits1-3 blinking with 16-frame half-period; start_game -> IDLE.
REQ-042 SHALL cover: reset asserted at frame 30 of CLEAR -> next clk IDLE with layer_en=9'h008.
REQ-043 SHALL cover: HIT_FLASH_EN undefined, player_hit in PLAY -> state and layer_en unchanged.
